// File: rtl/qed_dup_scheduler.sv
// qed_dup_scheduler: issues originals into a FIFO, then replays them with registers remapped to x16-x31
module qed_dup_scheduler #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             exec_dup,
  input  logic             in_valid,
  input  logic [31:0]      ifu_instruction,
  output logic             in_ready,
  input  logic             stall,
  output logic             out_valid,
  output logic [31:0]      qed_instruction,
  output logic [CNT_W-1:0] orig_count,
  output logic [CNT_W-1:0] dup_count,
  output logic             qed_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [31:0] NOP = 32'h0000007F;
  typedef enum logic [1:0] {ORIG, DUP, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] orig_q, orig_d, dup_q, dup_d;
  logic out_valid_q, out_valid_d, ready_q, ready_d;
  logic [31:0] instr_q, instr_d, head, dup_instr;
  logic empty, full, full_after, accept, push, pop;
  logic op_r, op_i, op_s, op_u;
  assign empty = wptr_q == rptr_q;
  assign full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign full_after = (wptr_d[AW] != rptr_q[AW]) && (wptr_d[AW-1:0] == rptr_q[AW-1:0]);
  assign in_ready = !rst && (ena ? (state_q == ORIG && !stall && !full) : !stall);
  assign accept = ena && in_valid && in_ready;
  assign push = accept && ifu_instruction[6:0] != 7'h7F;
  assign pop = ena && !stall && state_q == DUP;
  assign wptr_d = wptr_q + (AW+1)'(push);
  assign rptr_d = rptr_q + (AW+1)'(pop);
  assign head = mem_q[rptr_q[AW-1:0]];
  assign op_r = head[6:0] == 7'h33;
  assign op_i = head[6:0] == 7'h13 || head[6:0] == 7'h03;
  assign op_s = head[6:0] == 7'h23 || head[6:0] == 7'h63;
  assign op_u = head[6:0] == 7'h37;
  // bit4 of rs2 (24), rs1 (19) and rd (11) selects the upper register half
  assign dup_instr = head | {7'b0, op_r | op_s, 4'b0, op_r | op_i | op_s, 7'b0, op_r | op_i | op_u, 11'b0};
  assign out_valid = ena ? out_valid_q : in_valid;
  assign qed_instruction = ena ? instr_q : ifu_instruction;
  assign orig_count = orig_q;
  assign dup_count = dup_q;
  assign qed_ready = ready_q;
  always_ff @(posedge clk)
    if (rst) state_q <= ORIG;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (ena && !stall && state_q == ORIG && ((exec_dup && !empty) || full_after)) state_d = DUP;
    if (ena && !stall && state_q == DUP && rptr_d == wptr_q) state_d = DONE;
  end
  always_comb begin
    out_valid_d = out_valid_q;
    instr_d = instr_q;
    orig_d = orig_q;
    dup_d = dup_q;
    ready_d = ready_q;
    if (ena && !stall) begin
      out_valid_d = accept || state_q != ORIG;
      instr_d = state_q == DUP ? dup_instr : state_q == DONE ? NOP : accept ? ifu_instruction : instr_q;
      orig_d = orig_q + CNT_W'(push && orig_q != CMAX);
      dup_d = dup_q + CNT_W'(pop && dup_q != CMAX);
      ready_d = ready_q || (state_q == DONE && orig_q == dup_q && orig_q != '0);
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      orig_q <= '0;
      dup_q <= '0;
      out_valid_q <= 1'b0;
      instr_q <= NOP;
      ready_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      orig_q <= orig_d;
      dup_q <= dup_d;
      out_valid_q <= out_valid_d;
      instr_q <= instr_d;
      ready_q <= ready_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wptr_q[AW-1:0]] <= ifu_instruction;
endmodule

// File: tb/tb_qed_dup_scheduler.sv
// tb_qed_dup_scheduler: scoreboard bench; expected instruction stream queued at drive time
module tb_qed_dup_scheduler;
  logic clk = 0, rst = 0, ena = 0, exec_dup = 0, in_valid = 0, stall = 0;
  logic [31:0] ifu_instruction = 0;
  logic in_ready, out_valid, qed_ready;
  logic [31:0] qed_instruction;
  logic [3:0] orig_count, dup_count;
  int total = 0, bad = 0;
  logic [31:0] exp_q[$], got_q[$];

  qed_dup_scheduler #(.DEPTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .exec_dup(exec_dup), .in_valid(in_valid),
    .ifu_instruction(ifu_instruction), .in_ready(in_ready), .stall(stall),
    .out_valid(out_valid), .qed_instruction(qed_instruction),
    .orig_count(orig_count), .dup_count(dup_count), .qed_ready(qed_ready));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [31:0] remap(input logic [31:0] x);
    logic [31:0] y = x;
    case (x[6:0])
      7'b0110011: begin y[11] = 1; y[19] = 1; y[24] = 1; end
      7'b0010011, 7'b0000011: begin y[11] = 1; y[19] = 1; end
      7'b0100011, 7'b1100011: begin y[19] = 1; y[24] = 1; end
      7'b0110111: y[11] = 1;
      default: ;
    endcase
    return y;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    if (out_valid) got_q.push_back(qed_instruction);
  endtask

  task automatic do_reset();
    {in_valid, exec_dup, stall} = 0;
    ena = 1;
    rst = 1;
    cyc();
    rst = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    {in_valid, exec_dup, stall} = 0;
    ena = 1;
    rst = 1;
    @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    rst = 0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (qed_instruction !== 32'h7F) begin bad++; $display("FAIL reset_instr got=%h exp=0000007f", qed_instruction); end
    total++; if ({orig_count, dup_count, qed_ready} !== 9'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d/%0b exp=0/0/0", orig_count, dup_count, qed_ready); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_after got=%0b exp=1", in_ready); end
  endtask

  task automatic test_passthrough();
    do_reset();
    ena = 0;
    in_valid = 1;
    ifu_instruction = 32'h00500093;
    #1;
    total++; if (qed_instruction !== 32'h00500093 || out_valid !== 1'b1) begin bad++; $display("FAIL pass_comb got=%h/%0b exp=00500093/1", qed_instruction, out_valid); end
    ifu_instruction = 32'h00A00113;
    in_valid = 0;
    #1;
    total++; if (qed_instruction !== 32'h00A00113 || out_valid !== 1'b0) begin bad++; $display("FAIL pass_comb2 got=%h/%0b exp=00a00113/0", qed_instruction, out_valid); end
    in_valid = 1;
    cyc();
    total++; if (orig_count !== 4'd0) begin bad++; $display("FAIL pass_orig got=%0d exp=0", orig_count); end
    stall = 1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL pass_stall_ready got=%0b exp=0", in_ready); end
    stall = 0;
    in_valid = 0;
  endtask

  task automatic test_basic();
    do_reset();
    in_valid = 1;
    ifu_instruction = 32'h00500093;
    exp_q.push_back(32'h00500093);
    cyc();
    in_valid = 0;
    exec_dup = 1;
    cyc();
    exec_dup = 0;
    exp_q.push_back(32'h00580893);
    cyc();
    exp_q.push_back(32'h0000007F);
    cyc();
    total++; if (qed_ready !== 1'b1) begin bad++; $display("FAIL basic_qed_ready got=%0b exp=1", qed_ready); end
    total++; if (orig_count !== 4'd1 || dup_count !== 4'd1) begin bad++; $display("FAIL basic_counts got=%0d/%0d exp=1/1", orig_count, dup_count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready got=%0b exp=0", in_ready); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL basic_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_out[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]); end
    end
  endtask

  task automatic test_full();
    logic [31:0] ins[8];
    do_reset();
    for (int k = 0; k < 8; k++) begin
      ins[k] = {12'(k + 3), 5'(k), 3'b000, 5'(k + 1), 7'h13};
      in_valid = 1;
      ifu_instruction = ins[k];
      exp_q.push_back(ins[k]);
      cyc();
    end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%0b exp=0", in_ready); end
    total++; if (orig_count !== 4'd8) begin bad++; $display("FAIL full_orig got=%0d exp=8", orig_count); end
    ifu_instruction = 32'h00100013;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(remap(ins[k]));
      cyc();
    end
    in_valid = 0;
    total++; if (dup_count !== 4'd8) begin bad++; $display("FAIL full_dup got=%0d exp=8", dup_count); end
    exp_q.push_back(32'h0000007F);
    cyc();
    total++; if (qed_ready !== 1'b1) begin bad++; $display("FAIL full_qed_ready got=%0b exp=1", qed_ready); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL full_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad++; $display("FAIL full_out[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]); end
    end
  endtask

  task automatic test_remap_types();
    logic [31:0] ins[7] = '{32'h002081B3, 32'h0040A203, 32'h0030A423, 32'h00208463,
                           32'h123452B7, 32'h0080036F, 32'h0000007F};
    do_reset();
    foreach (ins[k]) begin
      in_valid = 1;
      ifu_instruction = ins[k];
      exp_q.push_back(ins[k]);
      cyc();
    end
    in_valid = 0;
    exec_dup = 1;
    cyc();
    exec_dup = 0;
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(remap(ins[k]));
      cyc();
    end
    exp_q.push_back(32'h0000007F);
    cyc();
    total++; if (orig_count !== 4'd6 || dup_count !== 4'd6 || qed_ready !== 1'b1) begin bad++; $display("FAIL remap_counts got=%0d/%0d/%0b exp=6/6/1", orig_count, dup_count, qed_ready); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL remap_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad++; $display("FAIL remap_out[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]); end
    end
  endtask

  task automatic test_nop_empty();
    do_reset();
    in_valid = 1;
    exec_dup = 1;
    ifu_instruction = 32'h0000007F;
    cyc();
    total++; if (out_valid !== 1'b1 || qed_instruction !== 32'h7F) begin bad++; $display("FAIL nop_out got=%h/%0b exp=0000007f/1", qed_instruction, out_valid); end
    total++; if (orig_count !== 4'd0) begin bad++; $display("FAIL nop_orig got=%0d exp=0", orig_count); end
    in_valid = 0;
    repeat (6) cyc();
    total++; if (qed_ready !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL nop_idle got=%0b/%0b exp=0/1", qed_ready, in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL nop_valid got=%0b exp=0", out_valid); end
    exec_dup = 0;
  endtask

  task automatic test_stall();
    logic [31:0] ins[4] = '{32'h00100093, 32'h00208133, 32'h0020A023, 32'h000011B7};
    logic [31:0] held;
    do_reset();
    foreach (ins[k]) begin
      in_valid = 1;
      ifu_instruction = ins[k];
      exp_q.push_back(ins[k]);
      cyc();
    end
    in_valid = 0;
    exec_dup = 1;
    cyc();
    exec_dup = 0;
    exp_q.push_back(remap(ins[0]));
    cyc();
    held = remap(ins[0]);
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      total++; if (qed_instruction !== held || out_valid !== 1'b1 || dup_count !== 4'd1) begin bad++; $display("FAIL stall_hold[%0d] got=%h/%0b/%0d exp=%h/1/1", k, qed_instruction, out_valid, dup_count, held); end
    end
    stall = 0;
    for (int k = 1; k < 4; k++) begin
      exp_q.push_back(remap(ins[k]));
      cyc();
    end
    exp_q.push_back(32'h0000007F);
    cyc();
    total++; if (dup_count !== 4'd4 || qed_ready !== 1'b1) begin bad++; $display("FAIL stall_done got=%0d/%0b exp=4/1", dup_count, qed_ready); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL stall_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad++; $display("FAIL stall_out[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1;
      ifu_instruction = {12'(k + 1), 5'(k), 3'b000, 5'(k + 2), 7'h13};
      cyc();
    end
    in_valid = 0;
    exec_dup = 1;
    cyc();
    exec_dup = 0;
    repeat (2) cyc();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    #1;
    total++; if (out_valid !== 1'b0 || qed_instruction !== 32'h7F) begin bad++; $display("FAIL rmid_out got=%h/%0b exp=0000007f/0", qed_instruction, out_valid); end
    total++; if ({orig_count, dup_count, qed_ready} !== 9'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL rmid_state got=%0d/%0d/%0b/%0b exp=0/0/0/1", orig_count, dup_count, qed_ready, in_ready); end
    got_q.delete();
    exp_q.delete();
    in_valid = 1;
    ifu_instruction = 32'h00500093;
    exp_q.push_back(32'h00500093);
    cyc();
    total++; if (orig_count !== 4'd1) begin bad++; $display("FAIL rmid_orig got=%0d exp=1", orig_count); end
    in_valid = 0;
    exec_dup = 1;
    cyc();
    exec_dup = 0;
    exp_q.push_back(32'h00580893);
    cyc();
    exp_q.push_back(32'h0000007F);
    cyc();
    total++; if (dup_count !== 4'd1 || qed_ready !== 1'b1) begin bad++; $display("FAIL rmid_done got=%0d/%0b exp=1/1", dup_count, qed_ready); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rmid_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rmid_out[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_basic();
    test_full();
    test_remap_types();
    test_nop_empty();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
